// File: rtl/clk_pkg.sv
// Shared definitions for the clock display datapath: digit indices, segment
// patterns and the BCD-to-seven-segment decoder.
package clk_pkg;

    localparam logic [2:0] DIG_SEC_LO  = 3'd0;
    localparam logic [2:0] DIG_SEC_HI  = 3'd1;
    localparam logic [2:0] DIG_MIN_LO  = 3'd2;
    localparam logic [2:0] DIG_MIN_HI  = 3'd3;
    localparam logic [2:0] DIG_HOUR_LO = 3'd4;
    localparam logic [2:0] DIG_HOUR_HI = 3'd5;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    function automatic logic bcd_invalid(input logic [3:0] bcd);
        return (bcd > 4'd9);
    endfunction

endpackage

// File: rtl/seg_scan_timebase.sv
// Digit-slot timebase: prescaler and digit index. idx/in_blank describe the
// state the counters take on the coming edge so registered outputs carry no lag.
module seg_scan_timebase
    import clk_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] idx,
    output logic       in_blank,
    output logic       frame_wrap
);

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);

    logic [PW-1:0] pre_r;
    logic [PW-1:0] pre_nxt_s;
    logic [2:0]    idx_r;
    logic [2:0]    idx_nxt_s;
    logic          slot_end_s;

    // Next-state of prescaler and digit index
    always_comb begin
        slot_end_s = (pre_r == PRE_LAST);
        pre_nxt_s  = pre_r + PW'(1);
        idx_nxt_s  = idx_r;
        if (slot_end_s) begin
            pre_nxt_s = '0;
            if (idx_r == DIG_HOUR_HI) begin
                idx_nxt_s = DIG_SEC_LO;
            end else begin
                idx_nxt_s = idx_r + 3'd1;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_r <= '0;
            idx_r <= DIG_SEC_LO;
        end else begin
            pre_r <= pre_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    assign idx        = idx_nxt_s;
    assign in_blank   = (pre_nxt_s < PRE_BLANK);
    assign frame_wrap = slot_end_s && (idx_r == DIG_HOUR_HI);

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot,
// blinking colon, field blink for time setting and sticky invalid-digit flag.
module seg_scan
    import clk_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8,
    parameter bit LZB       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_lo,
    input  logic [3:0] sec_hi,
    input  logic [3:0] min_lo,
    input  logic [3:0] min_hi,
    input  logic [3:0] hour_lo,
    input  logic [3:0] hour_hi,
    input  logic       tick_half,
    input  logic [5:0] edit_mask,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err
);

    logic [2:0]      idx_s;
    logic            in_blank_s;
    logic            frame_wrap_s;
    logic [5:0][3:0] live_s;
    logic [5:0][3:0] snap_r;
    logic [5:0][3:0] snap_nxt_s;
    logic            ph_r;
    logic            ph_nxt_s;
    logic            bad_s;
    logic [3:0]      digit_s;
    logic [5:0]      an_nxt_s;
    logic [6:0]      seg_nxt_s;
    logic            dp_nxt_s;

    seg_scan_timebase #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .in_blank   (in_blank_s),
        .frame_wrap (frame_wrap_s)
    );

    assign live_s = {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo};

    // Snapshot, blink phase and invalid-digit detection for the coming edge
    always_comb begin
        bad_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bad_s = bad_s | bcd_invalid(live_s[i]);
        end
        if (frame_wrap_s) begin
            snap_nxt_s = live_s;
        end else begin
            snap_nxt_s = snap_r;
        end
        ph_nxt_s = ph_r ^ tick_half;
        digit_s  = snap_nxt_s[idx_s];
    end

    // Output decode from next-state counters, snapshot and phase
    always_comb begin
        an_nxt_s  = 6'd0;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b0;
        if (!in_blank_s) begin
            an_nxt_s = 6'd1 << idx_s;
            dp_nxt_s = ph_nxt_s && ((idx_s == DIG_MIN_LO) || (idx_s == DIG_HOUR_LO));
            if (LZB && (idx_s == DIG_HOUR_HI) && (digit_s == 4'd0)) begin
                seg_nxt_s = SEG_OFF;
            end else begin
                seg_nxt_s = bcd_to_seg(digit_s);
            end
            // Field blink leaves the anode on so the duty stays uniform
            if (edit_mask[idx_s] && !ph_nxt_s) begin
                seg_nxt_s = SEG_OFF;
                dp_nxt_s  = 1'b0;
            end else begin
                dp_nxt_s  = dp_nxt_s;
            end
        end else begin
            an_nxt_s = 6'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_r <= '0;
            ph_r   <= 1'b1;
            err    <= 1'b0;
            an     <= 6'd0;
            seg    <= 7'd0;
            dp     <= 1'b0;
        end else begin
            snap_r <= snap_nxt_s;
            ph_r   <= ph_nxt_s;
            err    <= err | (frame_wrap_s & bad_s);
            an     <= an_nxt_s;
            seg    <= seg_nxt_s;
            dp     <= dp_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, BLANK_CYC=1, LZB=1.
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
    logic       tick_half;
    logic [5:0] edit_mask;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;

    int checks = 0;
    int errors = 0;

    seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .LZB(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_lo    (sec_lo),
        .sec_hi    (sec_hi),
        .min_lo    (min_lo),
        .min_hi    (min_hi),
        .hour_lo   (hour_lo),
        .hour_hi   (hour_hi),
        .tick_half (tick_half),
        .edit_mask (edit_mask),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [3:0] hh, hl, mh, ml, sh, sl);
        hour_hi = hh; hour_lo = hl; min_hi = mh; min_lo = ml; sec_hi = sh; sec_lo = sl;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick_half = 1'b0;
        edit_mask = 6'd0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        step(); step();
        checks++;
        if (an !== 6'd0 || seg !== 7'd0 || dp !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b err=%b, want 000000/00/0/0", an, seg, dp, err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 6'd0 || seg !== 7'd0) begin
            errors++;
            $display("FAIL post_reset_blank: an=%b seg=%h, want 000000/00", an, seg);
        end
        step();
        checks++;
        if (an !== 6'b000001 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL post_reset_slot0: an=%b seg=%h, want 000001/3f", an, seg);
        end
        repeat (23) step();
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (an !== 6'd0 || seg !== 7'd0 || dp !== 1'b0) begin
                errors++;
                $display("FAIL scan_blank slot %0d: an=%b seg=%h dp=%b, want 0", s, an, seg, dp);
            end
            for (int p = 1; p < 4; p++) begin
                step();
                checks++;
                if (an !== (6'd1 << s) || seg !== exp_seg[s] || dp !== (s == 2 || s == 4)) begin
                    errors++;
                    $display("FAIL scan slot %0d pre %0d: an=%b seg=%h dp=%b, want seg=%h", s, p, an, seg, dp, exp_seg[s]);
                end
            end
            step();
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        for (int f = 0; f < 2; f++) begin
            if (f == 1) exp_seg[0] = 7'h07;
            for (int s = 0; s < 6; s++) begin
                if (f == 0 && s == 3) sec_lo = 4'd7;
                if (f == 1 && s == 2) set_time(4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
                for (int p = 1; p < 4; p++) begin
                    step();
                    checks++;
                    if (an !== (6'd1 << s) || seg !== exp_seg[s]) begin
                        errors++;
                        $display("FAIL snapshot frame %0d slot %0d: an=%b seg=%h, want seg=%h", f, s, an, seg, exp_seg[s]);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6F, 7'h00};
        for (int s = 0; s < 6; s++) begin
            for (int p = 1; p < 4; p++) begin
                step();
                checks++;
                if (an !== (6'd1 << s) || seg !== exp_seg[s] || dp !== (s == 2 || s == 4)) begin
                    errors++;
                    $display("FAIL lzb slot %0d: an=%b seg=%h dp=%b, want seg=%h", s, an, seg, dp, exp_seg[s]);
                end
            end
            step();
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_seg [6];
        int s;
        int p;
        exp_seg = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6F, 7'h00};
        edit_mask = 6'b110000;
        for (int c = 0; c < 24; c++) begin
            s = c / 4;
            p = c % 4;
            if (c == 9) begin
                checks++;
                if (dp !== 1'b1) begin
                    errors++;
                    $display("FAIL blink_colon_before: dp=%b, want 1", dp);
                end
            end
            if (c == 15) begin
                checks++;
                if (an !== 6'b001000 || seg !== 7'h3F) begin
                    errors++;
                    $display("FAIL blink_unmasked: an=%b seg=%h, want 001000/3f", an, seg);
                end
            end
            if (c >= 16 && s >= 4 && p != 0) begin
                checks++;
                if (an !== (6'd1 << s) || seg !== 7'd0 || dp !== 1'b0) begin
                    errors++;
                    $display("FAIL blink_off slot %0d: an=%b seg=%h dp=%b, want seg=00 dp=0", s, an, seg, dp);
                end
            end
            if (c == 14) tick_half = 1'b1;
            step();
            tick_half = 1'b0;
        end
        for (int si = 0; si < 6; si++) begin
            if (si == 0) tick_half = 1'b1;
            for (int pi = 1; pi < 4; pi++) begin
                step();
                tick_half = 1'b0;
                checks++;
                if (an !== (6'd1 << si) || seg !== exp_seg[si] || dp !== (si == 2 || si == 4)) begin
                    errors++;
                    $display("FAIL blink_resume slot %0d: an=%b seg=%h dp=%b, want seg=%h", si, an, seg, dp, exp_seg[si]);
                end
            end
            step();
        end
        edit_mask = 6'd0;
    endtask

    task automatic test_invalid();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h00};
        hour_lo = 4'hC;
        repeat (23) step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: err=%b, want 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_rise: err=%b, want 1", err);
        end
        for (int s = 0; s < 6; s++) begin
            if (s == 1) hour_lo = 4'd9;
            for (int p = 1; p < 4; p++) begin
                step();
                checks++;
                if (an !== (6'd1 << s) || seg !== exp_seg[s]) begin
                    errors++;
                    $display("FAIL invalid slot %0d: an=%b seg=%h, want seg=%h", s, an, seg, exp_seg[s]);
                end
            end
            step();
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_reset_mid();
        repeat (14) step();
        checks++;
        if (an !== 6'b001000 || seg !== 7'h3F) begin
            errors++;
            $display("FAIL pre_reset_slot3: an=%b seg=%h, want 001000/3f", an, seg);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (an !== 6'd0 || seg !== 7'd0 || dp !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: an=%b seg=%h dp=%b err=%b, want all 0", an, seg, dp, err);
        end
        repeat (3) step();
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 6'd0 || seg !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_blank: an=%b seg=%h, want 0", an, seg);
        end
        step();
        checks++;
        if (an !== 6'b000001 || seg !== 7'h3F || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_slot0: an=%b seg=%h err=%b, want 000001/3f/0", an, seg, err);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_lzb();
        test_blink();
        test_invalid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed six-digit seven-segment display scanner for the clock datapath. It takes the six BCD time digits (hh:mm:ss) from the time counter and drives one digit at a time with a fixed dwell. A short blanking gap separates digits to suppress ghosting. It snapshots all six digits once per frame so a displayed frame never mixes two time values, and it adds a blinking colon and field-blink for time-setting mode.

## Interface
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 2..65535.
- BLANK_CYC, 8: cycles at the start of each slot with all anodes off; requires BLANK_CYC < SCAN_DIV.
- LZB, 1: when 1, the hours-tens digit is blanked if it is 0.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi  in  4 each  BCD digits from the time counter.
- tick_half  in  1  one-cycle pulse every 0.5 s; toggles blink phase.
- edit_mask  in  6  bit i set: digit i blinks (blanked while blink phase is 0).
- an  out  6  digit enables, active-high, one-hot or zero.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  out  1  decimal point (colon), active-high.
- err  out  1  sticky flag: a snapshot contained a digit > 9.

## Operation
- Digit index idx: 0=sec_lo, 1=sec_hi, 2=min_lo, 3=min_hi, 4=hour_lo, 5=hour_hi.
- Prescaler pre runs 0..SCAN_DIV-1 and is $clog2(SCAN_DIV) bits wide.
  - When pre == SCAN_DIV-1: pre wraps to 0 and idx advances, with 5 → 0.
- Slot phases, derived from pre:
  - BLANK (pre < BLANK_CYC): an=0, seg=0, dp=0.
  - SHOW (otherwise): an = 1<<idx, seg = decode(snap[idx]), dp as below.
- Frame snapshot: on the edge where idx wraps 5 → 0, all six input digits are loaded into snap. At no other time do inputs affect outputs, except tick_half and edit_mask.
- Decode for digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, bit0 = a).
- Invalid digit (> 9):
  - seg=0 for that slot.
  - err is set on the snapshot edge that loads it and holds until reset.
- Leading-zero blanking: if LZB=1 and snap[5]==0, seg=0 during slot 5. an is still asserted.
- Blink phase ph:
  - Reset value 1.
  - Toggles on each tick_half pulse.
- Field blink: in SHOW, if edit_mask[idx]=1 and ph=0, then seg=0 and dp=0. an is still asserted. edit_mask is sampled live, not snapshotted.
- Colon: dp=1 in SHOW of idx 2 or idx 4 when ph=1. Otherwise dp=0.

## Timing
- an, seg, dp are registered. On each edge they take the decode of the next-state values of idx, pre, snap, ph and edit_mask, so outputs are always consistent with the counter registers, with no extra lag.
- Reset values: pre=0, idx=0, snap=all 0, ph=1, err=0, an=0, seg=0, dp=0.
- After reset release:
  - Outputs stay in BLANK for BLANK_CYC cycles.
  - Slot 0 then shows 0x3F.
- Frame period is 6·SCAN_DIV cycles. Duty per digit is (SCAN_DIV−BLANK_CYC)/(6·SCAN_DIV).
- Input-to-display latency: a digit change becomes visible at the next frame start plus BLANK_CYC cycles, at most 6·SCAN_DIV + BLANK_CYC cycles later.
- Simultaneous events:
  - tick_half on the snapshot edge: both take effect in the same cycle.
  - edit_mask change mid-slot: takes effect on the next edge.
- Reset asserted mid-slot: all outputs go to 0 immediately (asynchronously). The frame restarts at idx 0.
- tick_half held high for N cycles toggles ph N times. The source must supply single-cycle pulses.

## Structure
- Shared clock package (clk_pkg) holds:
  - the digit index localparams (DIG_SEC_LO..DIG_HOUR_HI);
  - the SEG_0..SEG_9 and SEG_OFF constants;
  - a function bcd_to_seg(input [3:0]) returning [6:0], which returns SEG_OFF for values > 9.
- A single sub-module, seg_scan_timebase, holds the prescaler and idx counters. It outputs idx, in_blank and frame_wrap.
- The top level holds the snapshot, blink, decode and output registers.

## Test plan
- SCAN_DIV=4, BLANK_CYC=1, inputs 12:34:56, edit_mask=0:
  - Per slot, 1 cycle with an=0, then 3 cycles with an=000001 / seg=7D, 000010 / 6D, 000100 / 66, 001000 / 4F, 010000 / 5B, 100000 / 06.
  - dp=1 in slots 2 and 4.
- Change inputs from 12:34:56 to 12:34:57 mid-frame at slot 3:
  - Rest of the frame still shows ...56.
  - Slot 0 of the next frame shows 07.
  - No mixed frame.
- Inputs 09:00:00, LZB=1: slot 5 has an=100000 and seg=00; slot 4 has seg=6F.
- edit_mask=110000, two tick_half pulses 10 cycles apart:
  - Between the pulses (ph=0), slots 4 and 5 have seg=00 and all dp=0.
  - After the second pulse, normal display resumes.
- Snapshot containing hour_lo=4'hC: slot 4 seg=00, err rises on the snapshot edge and stays 1 after the inputs become legal.
- Assert rst low for 3 cycles mid-slot 3: an/seg/dp go to 0 asynchronously. After release: BLANK for 1 cycle, then slot 0 shows 3F (snap=0), and err=0.
